// File: rtl/mc_ctrl_if.sv
// Memory-port bundle between mc_ctrl and the shared instruction/data memory.
//   MemRead  : read request (instruction fetch or load)
//   MemWrite : write request (store)
//   IorD     : address select, 0 = PC, 1 = ALU result register
//   LAddr    : load width/sign select (lw 000, lb 001, lbu 010, lh 011, lhu 100)
//   SAddr    : store width select (sw 00, sb 01, sh 10)
//   mem_rdy  : memory completes the current access this cycle
interface mc_ctrl_if;
    logic       MemRead;
    logic       MemWrite;
    logic       IorD;
    logic [2:0] LAddr;
    logic [1:0] SAddr;
    logic       mem_rdy;

    modport master (output MemRead, MemWrite, IorD, LAddr, SAddr, input mem_rdy);
    modport slave  (input  MemRead, MemWrite, IorD, LAddr, SAddr, output mem_rdy);
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle control unit: decodes Op/Funct from the registered IR and steps
// each instruction through IF/ID/EX/MEM/WB, with illegal-op and memory-timeout
// traps and a one-cycle retire pulse.
//   clk, rst       : clock, synchronous active-high reset
//   Op, Funct      : IR[31:26], IR[5:0]
//   Zero           : ALU zero flag (beq)
//   bus            : memory port (requests out, mem_rdy in)
//   PCWrite..WDSel : datapath strobes and selects
//   instr_done     : retire pulse
//   illegal,bus_err: sticky trap causes
//   state          : current FSM state (IF 0 .. WB 4, TRAP 7)
module mc_ctrl #(
    parameter int ALUOP_W = 3,
    parameter int MEM_TO  = 15,
    parameter int HS_EN   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    mc_ctrl_if.master          bus,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               EXTOp,
    output logic               ALUSrc,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         NPCOp,
    output logic [1:0]         GPRSel,
    output logic [1:0]         WDSel,
    output logic               instr_done,
    output logic               illegal,
    output logic               bus_err,
    output logic [2:0]         state
);
    typedef enum logic [2:0] {
        S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd7
    } state_t;

    localparam int            CW     = (MEM_TO < 1) ? 1 : $clog2(MEM_TO + 1);
    localparam logic [CW-1:0] TO_VAL = CW'(MEM_TO);

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic          r_illegal, r_bus_err;

    // Decode
    logic       w_rtype, w_addi, w_ori, w_load, w_store, w_beq, w_j, w_jal, w_legal;
    logic       w_src, w_ext;
    logic [2:0] w_alu3, w_laddr;
    logic [1:0] w_saddr;

    always_comb begin
        w_rtype = 1'b0; w_addi = 1'b0; w_ori = 1'b0; w_load = 1'b0;
        w_store = 1'b0; w_beq = 1'b0; w_j = 1'b0; w_jal = 1'b0;
        w_alu3 = 3'd0; w_laddr = 3'd0; w_saddr = 2'd0;
        case (Op)
            6'b000000: begin
                w_rtype = 1'b1;
                case (Funct)
                    6'b100000, 6'b100001: w_alu3 = 3'd1;
                    6'b100010, 6'b100011: w_alu3 = 3'd2;
                    6'b100100:            w_alu3 = 3'd3;
                    6'b100101:            w_alu3 = 3'd4;
                    6'b101010:            w_alu3 = 3'd5;
                    6'b101011:            w_alu3 = 3'd6;
                    default:              w_rtype = 1'b0;
                endcase
            end
            6'b001000: begin w_addi = 1'b1;  w_alu3 = 3'd1; end
            6'b001101: begin w_ori = 1'b1;   w_alu3 = 3'd4; end
            6'b100011: begin w_load = 1'b1;  w_alu3 = 3'd1; w_laddr = 3'b000; end
            6'b100000: begin w_load = 1'b1;  w_alu3 = 3'd1; w_laddr = 3'b001; end
            6'b100100: begin w_load = 1'b1;  w_alu3 = 3'd1; w_laddr = 3'b010; end
            6'b100001: begin w_load = 1'b1;  w_alu3 = 3'd1; w_laddr = 3'b011; end
            6'b100101: begin w_load = 1'b1;  w_alu3 = 3'd1; w_laddr = 3'b100; end
            6'b101011: begin w_store = 1'b1; w_alu3 = 3'd1; w_saddr = 2'b00; end
            6'b101000: begin w_store = 1'b1; w_alu3 = 3'd1; w_saddr = 2'b01; end
            6'b101001: begin w_store = 1'b1; w_alu3 = 3'd1; w_saddr = 2'b10; end
            6'b000100: begin w_beq = 1'b1;   w_alu3 = 3'd2; end
            6'b000010: w_j   = 1'b1;
            6'b000011: w_jal = 1'b1;
            default: ;
        endcase
    end

    assign w_legal = w_rtype | w_addi | w_ori | w_load | w_store | w_beq | w_j | w_jal;
    assign w_src   = w_addi | w_ori | w_load | w_store;
    assign w_ext   = w_addi | w_load | w_store;

    // Handshake and timeout: only IF and MEM wait on memory.
    logic w_ready, w_wait_st, w_timeout;
    assign w_ready   = (HS_EN != 0) ? bus.mem_rdy : 1'b1;
    assign w_wait_st = (r_state == S_IF) || (r_state == S_MEM);
    assign w_timeout = w_wait_st && !w_ready && (r_cnt == TO_VAL);

    // State register, wait counter and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IF;
            r_cnt     <= '0;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_next;
            // Any exit from IF/MEM happens on ready or timeout, both of which clear.
            r_cnt   <= (w_wait_st && !w_ready && !w_timeout) ? r_cnt + CW'(1) : '0;
            if (r_state == S_ID && !w_legal) r_illegal <= 1'b1;
            if (w_timeout)                   r_bus_err <= 1'b1;
        end
    end

    // Next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IF:    if (w_timeout) w_next = S_TRAP;
                     else if (w_ready) w_next = S_ID;
            S_ID:    if (!w_legal) w_next = S_TRAP;
                     else if (w_j) w_next = S_IF;
                     else if (w_jal) w_next = S_WB;
                     else w_next = S_EX;
            S_EX:    if (w_beq) w_next = S_IF;
                     else if (w_load || w_store) w_next = S_MEM;
                     else w_next = S_WB;
            S_MEM:   if (w_timeout) w_next = S_TRAP;
                     else if (w_ready) w_next = w_load ? S_WB : S_IF;
            S_WB:    w_next = S_IF;
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_IF;
        endcase
    end

    // Outputs; rst forces everything low regardless of the registered state.
    always_comb begin
        PCWrite = 1'b0; IRWrite = 1'b0; RegWrite = 1'b0; EXTOp = 1'b0; ALUSrc = 1'b0;
        ALUOp = '0; NPCOp = 2'b00; GPRSel = 2'b00; WDSel = 2'b00; instr_done = 1'b0;
        bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.IorD = 1'b0;
        bus.LAddr = 3'd0; bus.SAddr = 2'd0;
        if (!rst) begin
            case (r_state)
                S_IF: begin
                    bus.MemRead = 1'b1;
                    if (w_ready) begin IRWrite = 1'b1; PCWrite = 1'b1; end
                end
                S_ID: if (w_legal && w_j) begin
                    PCWrite = 1'b1; NPCOp = 2'b10; instr_done = 1'b1;
                end
                S_EX: begin
                    ALUOp  = ALUOP_W'(w_alu3);
                    ALUSrc = w_src;
                    EXTOp  = w_ext;
                    if (w_beq) begin PCWrite = Zero; NPCOp = 2'b01; instr_done = 1'b1; end
                end
                S_MEM: begin
                    bus.IorD = 1'b1;
                    if (w_load) begin bus.MemRead = 1'b1; bus.LAddr = w_laddr; end
                    // A write strobe is never issued on the cycle that traps.
                    if (w_store) begin bus.MemWrite = !w_timeout; bus.SAddr = w_saddr; end
                    if (w_store && w_ready) instr_done = 1'b1;
                end
                S_WB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    GPRSel     = w_rtype ? 2'b00 : (w_jal ? 2'b10 : 2'b01);
                    WDSel      = w_load ? 2'b01 : (w_jal ? 2'b10 : 2'b00);
                    bus.LAddr  = w_laddr;
                end
                default: ;
            endcase
        end
    end

    assign illegal = r_illegal & ~rst;
    assign bus_err = r_bus_err & ~rst;
    assign state   = rst ? S_IF : r_state;
endmodule

// File: tb/tb_mc_ctrl.sv
module tb_mc_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] Op = '0, Funct = '0;
    logic       Zero = 1'b0, mem_rdy = 1'b1, sel = 1'b0;
    int         nerr = 0, nchk = 0;

    always #5 clk = ~clk;

    typedef struct packed {
        logic pcw, irw, iord, mr, mw, rw, ext, src;
        logic [2:0] alu; logic [1:0] npc, gpr, wd; logic [2:0] la; logic [1:0] sa;
        logic done, ill, berr; logic [2:0] st;
    } obs_t;

    mc_ctrl_if bus1();
    mc_ctrl_if bus2();
    assign bus1.mem_rdy = mem_rdy;
    assign bus2.mem_rdy = 1'b0;

    logic pcw1, irw1, rw1, ext1, src1, done1, ill1, berr1;
    logic pcw2, irw2, rw2, ext2, src2, done2, ill2, berr2;
    logic [2:0] alu1, alu2, st1, st2;
    logic [1:0] npc1, npc2, gpr1, gpr2, wd1, wd2;

    mc_ctrl #(.ALUOP_W(3), .MEM_TO(15), .HS_EN(1)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .bus(bus1),
        .PCWrite(pcw1), .IRWrite(irw1), .RegWrite(rw1), .EXTOp(ext1), .ALUSrc(src1),
        .ALUOp(alu1), .NPCOp(npc1), .GPRSel(gpr1), .WDSel(wd1), .instr_done(done1),
        .illegal(ill1), .bus_err(berr1), .state(st1));

    mc_ctrl #(.ALUOP_W(3), .MEM_TO(15), .HS_EN(0)) dut_nohs (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .bus(bus2),
        .PCWrite(pcw2), .IRWrite(irw2), .RegWrite(rw2), .EXTOp(ext2), .ALUSrc(src2),
        .ALUOp(alu2), .NPCOp(npc2), .GPRSel(gpr2), .WDSel(wd2), .instr_done(done2),
        .illegal(ill2), .bus_err(berr2), .state(st2));

    obs_t o1, o2, o;
    assign o1 = {pcw1, irw1, bus1.IorD, bus1.MemRead, bus1.MemWrite, rw1, ext1, src1,
                 alu1, npc1, gpr1, wd1, bus1.LAddr, bus1.SAddr, done1, ill1, berr1, st1};
    assign o2 = {pcw2, irw2, bus2.IorD, bus2.MemRead, bus2.MemWrite, rw2, ext2, src2,
                 alu2, npc2, gpr2, wd2, bus2.LAddr, bus2.SAddr, done2, ill2, berr2, st2};
    assign o  = sel ? o2 : o1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-run observations
    int          lat, trap_cyc, memreq, rwcnt;
    logic        any_wr;
    logic [4:0]  ex_snap;
    logic [13:0] ret_snap;
    logic [11:0] hist;
    obs_t        post;

    // Reset, then run one instruction; if_w / mem_w = cycles of mem_rdy low in IF / MEM.
    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int if_w, input int mem_w, input logic s);
        int iw, mw;
        sel = s; Op = op; Funct = fn; Zero = z; mem_rdy = 1'b1; rst = 1'b1;
        #1;
        chk("rst_outs_zero", o, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        lat = 0; trap_cyc = 0; memreq = 0; rwcnt = 0; any_wr = 1'b0;
        ex_snap = '0; ret_snap = '0; hist = '0; iw = 0; mw = 0;
        for (int c = 1; c <= 60; c++) begin
            if (o.st == 3'd0 && iw < if_w) begin mem_rdy = 1'b0; iw++; end
            else if (o.st == 3'd3 && mw < mem_w) begin mem_rdy = 1'b0; mw++; end
            else mem_rdy = 1'b1;
            #1;
            if (c == 1) chk("reset_state", {o.st, o.ill, o.berr}, 0);
            hist = {hist[8:0], o.st};
            if (o.st == 3'd2) ex_snap = {o.alu, o.src, o.ext};
            if (o.st == 3'd3 && o.mr && o.iord) memreq++;
            if (o.rw) rwcnt++;
            if (o.rw || o.mw) any_wr = 1'b1;
            if (o.done) begin
                lat = c;
                ret_snap = {o.pcw, o.npc, o.rw, o.gpr, o.wd, o.mw, o.sa, o.la};
                break;
            end
            if (o.st == 3'd7) begin trap_cyc = c; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        mem_rdy = 1'b1;
        #1;
        post = o;
    endtask

    typedef struct {
        logic [5:0] op, fn; logic z; int lat;
        logic [2:0] alu; logic src, ext;
        logic pcw; logic [1:0] npc; logic rw; logic [1:0] gpr, wd;
        logic mw; logic [1:0] sa; logic [2:0] la;
    } vec_t;

    vec_t vecs[22];

    initial begin
        //          op     fn     z     lat alu   src   ext   pcw   npc    rw    gpr    wd     mw    sa     la
        vecs[0]  = '{6'h00, 6'h20, 1'b0, 4, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 3'd0}; // add
        vecs[1]  = '{6'h00, 6'h21, 1'b0, 4, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 3'd0}; // addu
        vecs[2]  = '{6'h00, 6'h22, 1'b0, 4, 3'd2, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 3'd0}; // sub
        vecs[3]  = '{6'h00, 6'h23, 1'b0, 4, 3'd2, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 3'd0}; // subu
        vecs[4]  = '{6'h00, 6'h24, 1'b0, 4, 3'd3, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 3'd0}; // and
        vecs[5]  = '{6'h00, 6'h25, 1'b0, 4, 3'd4, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 3'd0}; // or
        vecs[6]  = '{6'h00, 6'h2A, 1'b0, 4, 3'd5, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 3'd0}; // slt
        vecs[7]  = '{6'h00, 6'h2B, 1'b0, 4, 3'd6, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 3'd0}; // sltu
        vecs[8]  = '{6'h08, 6'h00, 1'b0, 4, 3'd1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 2'd1, 2'd0, 1'b0, 2'd0, 3'd0}; // addi
        vecs[9]  = '{6'h0D, 6'h00, 1'b0, 4, 3'd4, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 2'd0, 1'b0, 2'd0, 3'd0}; // ori
        vecs[10] = '{6'h23, 6'h00, 1'b0, 5, 3'd1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 2'd1, 2'd1, 1'b0, 2'd0, 3'd0}; // lw
        vecs[11] = '{6'h20, 6'h00, 1'b0, 5, 3'd1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 2'd1, 2'd1, 1'b0, 2'd0, 3'd1}; // lb
        vecs[12] = '{6'h24, 6'h00, 1'b0, 5, 3'd1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 2'd1, 2'd1, 1'b0, 2'd0, 3'd2}; // lbu
        vecs[13] = '{6'h21, 6'h00, 1'b0, 5, 3'd1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 2'd1, 2'd1, 1'b0, 2'd0, 3'd3}; // lh
        vecs[14] = '{6'h25, 6'h00, 1'b0, 5, 3'd1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 2'd1, 2'd1, 1'b0, 2'd0, 3'd4}; // lhu
        vecs[15] = '{6'h2B, 6'h00, 1'b0, 4, 3'd1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd0, 3'd0}; // sw
        vecs[16] = '{6'h28, 6'h00, 1'b0, 4, 3'd1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd1, 3'd0}; // sb
        vecs[17] = '{6'h29, 6'h00, 1'b0, 4, 3'd1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd2, 3'd0}; // sh
        vecs[18] = '{6'h04, 6'h00, 1'b1, 3, 3'd2, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 3'd0}; // beq taken
        vecs[19] = '{6'h04, 6'h00, 1'b0, 3, 3'd2, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 3'd0}; // beq not taken
        vecs[20] = '{6'h02, 6'h00, 1'b0, 2, 3'd0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 3'd0}; // j
        vecs[21] = '{6'h03, 6'h00, 1'b0, 3, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 2'd2, 1'b0, 2'd0, 3'd0}; // jal

        for (int i = 0; i < 22; i++) begin
            run(vecs[i].op, vecs[i].fn, vecs[i].z, 0, 0, 1'b0);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_ex", i), ex_snap, {vecs[i].alu, vecs[i].src, vecs[i].ext});
            chk($sformatf("v%0d_retire", i), ret_snap,
                {vecs[i].pcw, vecs[i].npc, vecs[i].rw, vecs[i].gpr, vecs[i].wd,
                 vecs[i].mw, vecs[i].sa, vecs[i].la});
        end

        // add: state walk, single register write, back in IF with no extra retire
        run(6'h00, 6'h20, 1'b0, 0, 0, 1'b0);
        chk("add_states", hist, {3'd0, 3'd1, 3'd2, 3'd4});
        chk("add_rw_cnt", rwcnt, 1);
        chk("add_post", {post.st, post.done}, {3'd0, 1'b0});

        // lb with 3 wait cycles in MEM
        run(6'h20, 6'h00, 1'b0, 0, 3, 1'b0);
        chk("lb_wait_lat", lat, 8);
        chk("lb_wait_req", memreq, 4);
        chk("lb_wait_wb", {ret_snap[7:6], ret_snap[2:0]}, {2'b01, 3'b001});

        // illegal opcode and illegal funct
        run(6'h3F, 6'h00, 1'b0, 0, 0, 1'b0);
        chk("ill_op_trap", trap_cyc, 3);
        chk("ill_op_flags", {o.ill, o.berr}, 2'b10);
        chk("ill_op_nowr", any_wr, 0);
        chk("ill_op_hold", {post.st, post.done, post.mr}, {3'd7, 1'b0, 1'b0});
        run(6'h00, 6'h00, 1'b0, 0, 0, 1'b0);
        chk("ill_fn_trap", trap_cyc, 3);
        chk("ill_fn_flag", post.ill, 1);

        // fetch timeout, and ready arriving on the last allowed cycle
        run(6'h00, 6'h20, 1'b0, 100, 0, 1'b0);
        chk("if_to_trap", trap_cyc, 17);
        chk("if_to_flags", {post.ill, post.berr, post.st}, {1'b0, 1'b1, 3'd7});
        chk("if_to_nodone", lat, 0);
        run(6'h00, 6'h20, 1'b0, 15, 0, 1'b0);
        chk("if_edge_lat", lat, 19);
        chk("if_edge_noerr", post.berr, 0);

        // data-phase timeout on a load
        run(6'h23, 6'h00, 1'b0, 0, 100, 1'b0);
        chk("mem_to_trap", trap_cyc, 20);
        chk("mem_to_req", memreq, 16);
        chk("mem_to_flag", post.berr, 1);

        // HS_EN=0: mem_rdy tied low, lw still completes
        run(6'h23, 6'h00, 1'b0, 0, 0, 1'b1);
        chk("nohs_lw_lat", lat, 5);
        sel = 1'b0;

        // reset while a store waits in MEM
        Op = 6'h2B; Funct = 6'h00; Zero = 1'b0; mem_rdy = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        begin
            int c;
            for (c = 0; c < 10; c++) begin
                mem_rdy = (o.st == 3'd3) ? 1'b0 : 1'b1;
                #1;
                if (o.st == 3'd3) break;
                @(posedge clk); #1;
            end
            chk("sw_reach_mem", (c < 10), 1);
        end
        chk("sw_mw_held", {o.mw, o.iord, o.sa}, {1'b1, 1'b1, 2'b00});
        @(posedge clk); #1;
        #1;
        chk("sw_mw_wait2", {o.st, o.mw}, {3'd3, 1'b1});
        rst = 1'b1;
        #1;
        chk("sw_rst_outs", o, 0);
        @(posedge clk); #1;
        rst = 1'b0; mem_rdy = 1'b0;
        #1;
        chk("sw_rst_after", {o.st, o.ill, o.berr, o.mr, o.mw}, {3'd0, 1'b0, 1'b0, 1'b1, 1'b0});

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle successor to the single-cycle CPU control decoder. Decodes Op/Funct from the registered IR and sequences each instruction through IF/ID/EX/MEM/WB states. Memory accesses use a ready handshake with a parametrised timeout. Adds illegal-opcode and bus-timeout trapping, a retire pulse, and byte/half store selection (sb/sh). Sits between the IR/datapath registers and a shared instruction/data memory port.

Parameters:
ALUOP_W, 3, ALUOp width; codes occupy the low 3 bits, upper bits driven 0
MEM_TO, 15, max wait cycles for mem_rdy before trap (1..255)
HS_EN, 1, 1 = honour mem_rdy; 0 = memory treated as single-cycle (mem_rdy ignored, always ready)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
Op  in  6  IR[31:26]
Funct  in  6  IR[5:0]
Zero  in  1  ALU zero flag
mem_rdy  in  1  memory completes current access this cycle
PCWrite  out  1  load PC from NPC
IRWrite  out  1  load IR from memory read data
IorD  out  1  memory address select: 0 = PC, 1 = ALU result register
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
RegWrite  out  1  register file write
EXTOp  out  1  sign-extend immediate
ALUSrc  out  1  ALU B from immediate
ALUOp  out  ALUOP_W  NOP0 ADD1 SUB2 AND3 OR4 SLT5 SLTU6
NPCOp  out  2  PLUS4 00, BRANCH 01, JUMP 10
GPRSel  out  2  RD 00, RT 01, $31 10
WDSel  out  2  ALU 00, MEM 01, PC 10
LAddr  out  3  lw 000, lb 001, lbu 010, lh 011, lhu 100
SAddr  out  2  sw 00, sb 01, sh 10
instr_done  out  1  one-cycle retire pulse
illegal  out  1  sticky: unsupported opcode/funct
bus_err  out  1  sticky: memory timeout
state  out  3  IF 0, ID 1, EX 2, MEM 3, WB 4, TRAP 7

Behaviour:
- Supported: add sub and or slt sltu addu subu, addi ori, lw lb lh lbu lhu, sw sb(101000) sh(101001), beq, j, jal. Encodings and ALU/EXT/GPR/WD mapping are unchanged from the single-cycle decoder. Any other Op/Funct is illegal.
- Reset: state=IF, wait counter=0, illegal=bus_err=0. All outputs are 0 while rst is high, overriding the FSM.
- Outputs are combinational from state and decode. Unlisted outputs are 0 in each state.
- IF: MemRead=1, IorD=0. When ready: IRWrite=1, PCWrite=1, NPCOp=00, go to ID. Otherwise stay.
- ID: illegal -> TRAP (set illegal). j: PCWrite=1, NPCOp=10, instr_done, go to IF. jal -> WB. All others -> EX.
- EX: ALUOp/ALUSrc/EXTOp per decode.
  - beq: ALUOp=SUB; PCWrite=Zero, NPCOp=01; instr_done; go to IF.
  - R-type/addi/ori -> WB.
  - loads/stores: ALUOp=ADD, ALUSrc=1, EXTOp=1 -> MEM.
- MEM: IorD=1. Loads: MemRead=1, LAddr valid. Stores: MemWrite=1, SAddr valid.
  - Request is held every cycle until ready.
  - On ready: loads -> WB; stores assert instr_done and go to IF.
- WB: RegWrite=1, instr_done, go to IF.
  - R-type: GPRSel=00, WDSel=00. addi/ori: GPRSel=01, WDSel=00.
  - Loads: GPRSel=01, WDSel=01, LAddr held. jal: GPRSel=10, WDSel=10 (PC already +4).
- ready = mem_rdy if HS_EN=1, else 1.
- Wait counter (width $clog2(MEM_TO+1)):
  - Counts cycles in IF/MEM without ready; clears on ready or state exit.
  - On the cycle counter==MEM_TO without ready: go to TRAP, set bus_err; no IRWrite/PCWrite/RegWrite/MemWrite that cycle.
  - mem_rdy on that same cycle wins: normal completion, no trap.
- TRAP: all strobes 0; held until rst. illegal and bus_err stay sticky.
- Reset mid-operation (any state, including MEM with MemWrite high): strobes drop in the rst cycle; IF on the next edge.
- Latency with ready always 1 (cycles, IF to retire): j 2, beq 3, jal 3, R/imm 4, store 4, load 5. Each memory wait cycle adds 1.
- instr_done: exactly one pulse per retired instruction; never asserted in TRAP.

Test Plan:
- HS_EN=1, mem_rdy=1; add (Op 0, Funct 100000) -> states 0,1,2,4; RegWrite only in WB with GPRSel=00; ALUOp=001 in EX; one instr_done.
- lb (Op 100000) with mem_rdy low 3 cycles in MEM -> MemRead and IorD held 4 cycles, LAddr=001; WB WDSel=01; total 8 cycles.
- beq with Zero=1 -> PCWrite=1, NPCOp=01 in EX. With Zero=0 -> PCWrite=0. Both retire in 3 cycles.
- jal -> WB with GPRSel=10, WDSel=10, RegWrite=1. j -> PCWrite, NPCOp=10 in ID; retires in 2 cycles.
- Op 111111 -> TRAP after ID, illegal=1, no RegWrite/MemWrite. mem_rdy stuck low with MEM_TO=15: IF 16 cycles -> TRAP, bus_err=1. mem_rdy on cycle 16 -> no trap.
- Assert rst during sw MEM wait -> MemWrite=0 that cycle; state=0 and flags 0 next cycle. HS_EN=0 with mem_rdy=0 -> lw completes in 5 cycles.
